// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the pipeline hazard/interlock controller.
//   RA_W_DFLT   : default register address width
//   RA_W_MAX    : widest register address a tracked entry can hold
//   FWD_REGFILE : forwarding select meaning "use the regfile value latched at D"
//   hz_entry_t  : one in-flight destination entry {valid, rd, we, is_load}
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int RA_W_DFLT   = 5;
    localparam int RA_W_MAX    = 8;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                we;
        logic                is_load;
    } hz_entry_t;

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Combinational priority encoder over the tracked entries for one D source.
// The youngest matching entry decides the outcome:
//   - a load that is still too young to forward raises lu_hit, and lu_wait
//     gives the remaining stall cycles minus one;
//   - otherwise sel names the entry that will hold the producer once D
//     advances (entry i now becomes entry i+1);
//   - a producer found only in the last stage leaves sel at FWD_REGFILE,
//     because the regfile read already sees that writeback.
// Ports:
//   entries  in  DEPTH x hz_entry_t  tracked entries, [0] = E
//   src      in  RA_W_MAX            source register address (zero-extended)
//   use_src  in  1                   source is really read by a valid D
//   sel      out SEL_W               forwarding select for the next E cycle
//   lu_hit   out 1                   load-use hazard on this source
//   lu_wait  out CNT_W               stall cycles still needed after this one
// -----------------------------------------------------------------------------
module fwd_match
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(LOAD_LAT + 1)
) (
    input  hz_entry_t [DEPTH-1:0] entries,
    input  logic [RA_W_MAX-1:0]   src,
    input  logic                  use_src,
    output logic [SEL_W-1:0]      sel,
    output logic                  lu_hit,
    output logic [CNT_W-1:0]      lu_wait
);

    logic found;

    always_comb begin
        sel     = SEL_W'(FWD_REGFILE);
        lu_hit  = 1'b0;
        lu_wait = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // x0 is hard-wired, so an rd of zero never produces anything
            if (!found && use_src && entries[i].valid && entries[i].we &&
                (entries[i].rd != '0) && (entries[i].rd == src)) begin
                found = 1'b1;
                if (entries[i].is_load && (i < LOAD_LAT - 1)) begin
                    lu_hit  = 1'b1;
                    lu_wait = CNT_W'(LOAD_LAT - 2 - i);
                end else if (i < DEPTH - 1) begin
                    sel = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and interlock controller for the in-order pipeline. Tracks the
// destination of the instruction in E and the DEPTH-1 stages after it, and
// produces stall / flush / bubble controls plus registered forwarding selects
// for the E-stage operands.
// Optional feature macro: PIPE_HAZARD_PERF_EN adds saturating counters
// perf_stall_cycles and perf_flushes.
// Ports:
//   clock                    in  rising-edge clock
//   reset                    in  asynchronous active-low reset
//   d_valid                  in  D holds a real instruction
//   d_rs1, d_rs2             in  D source register addresses
//   d_use_rs1, d_use_rs2     in  source is actually read
//   d_rd, d_we, d_is_load    in  D destination, write enable, load flag
//   redirect_valid           in  taken branch / jump resolved in E
//   mem_stall                in  dmem not ready, freeze the whole pipe
//   stall_f, stall_d         out hold PC / hold D
//   flush_f, flush_d         out kill F / D
//   bubble_e                 out load a NOP into E
//   fwd_rs1_sel, fwd_rs2_sel out E operand source (0 = regfile, k = entry k)
//   perf_stall_cycles        out (PIPE_HAZARD_PERF_EN) load-use + mem stall cycles
//   perf_flushes             out (PIPE_HAZARD_PERF_EN) accepted redirects
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int RA_W     = RA_W_DFLT,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [RA_W-1:0]  d_rs1,
    input  logic [RA_W-1:0]  d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [RA_W-1:0]  d_rd,
    input  logic             d_we,
    input  logic             d_is_load,
    input  logic             redirect_valid,
    input  logic             mem_stall,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_f,
    output logic             flush_d,
    output logic             bubble_e,
    output logic [SEL_W-1:0] fwd_rs1_sel,
    output logic [SEL_W-1:0] fwd_rs2_sel
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_flushes
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    hz_entry_t [DEPTH-1:0] entry;
    hz_entry_t             d_entry;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      lu_wait1;
    logic [CNT_W-1:0]      lu_wait2;
    logic [CNT_W-1:0]      lu_wait;
    logic [SEL_W-1:0]      sel1;
    logic [SEL_W-1:0]      sel2;
    logic                  lu1;
    logic                  lu2;
    logic                  live;
    logic                  freeze;
    logic                  redirect;
    logic                  load_use;
    logic [RA_W_MAX-1:0]   rs1_x;
    logic [RA_W_MAX-1:0]   rs2_x;

    assign rs1_x   = RA_W_MAX'(d_rs1);
    assign rs2_x   = RA_W_MAX'(d_rs2);
    assign d_entry = '{valid: d_valid, rd: RA_W_MAX'(d_rd), we: d_we, is_load: d_is_load};

    fwd_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W)
    ) u_match_rs1 (
        .entries (entry),
        .src     (rs1_x),
        .use_src (d_use_rs1 & d_valid),
        .sel     (sel1),
        .lu_hit  (lu1),
        .lu_wait (lu_wait1)
    );

    fwd_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W)
    ) u_match_rs2 (
        .entries (entry),
        .src     (rs2_x),
        .use_src (d_use_rs2 & d_valid),
        .sel     (sel2),
        .lu_hit  (lu2),
        .lu_wait (lu_wait2)
    );

    // live stays low through reset and the first cycle after release, which
    // keeps every control output quiet until the pipe is really running.
    // Redirect outranks load-use; mem_stall outranks both and defers them.
    always_comb begin
        freeze   = live & mem_stall;
        redirect = live & ~mem_stall & redirect_valid & entry[0].valid;
        load_use = live & ~mem_stall & ~redirect & (lu1 | lu2);
        lu_wait  = (lu_wait1 > lu_wait2) ? lu_wait1 : lu_wait2;
        stall_f  = freeze | load_use;
        stall_d  = freeze | load_use;
        flush_f  = redirect;
        flush_d  = redirect;
        bubble_e = load_use;
    end

    // D -> E boundary and the tracked chain behind E
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry       <= '0;
            stall_cnt   <= '0;
            fwd_rs1_sel <= SEL_W'(FWD_REGFILE);
            fwd_rs2_sel <= SEL_W'(FWD_REGFILE);
            live        <= 1'b0;
        end else begin
            live <= 1'b1;
            if (!freeze) begin
                for (int k = 1; k < DEPTH; k++) begin
                    entry[k] <= entry[k-1];
                end
                if (load_use || redirect) begin
                    entry[0]    <= '0;
                    fwd_rs1_sel <= SEL_W'(FWD_REGFILE);
                    fwd_rs2_sel <= SEL_W'(FWD_REGFILE);
                end else begin
                    entry[0]    <= d_entry;
                    fwd_rs1_sel <= sel1;
                    fwd_rs2_sel <= sel2;
                end
                // Counts down the remaining load-use cycles; the stall itself
                // follows the match, which clears as the load moves along.
                if (redirect) begin
                    stall_cnt <= '0;
                end else if (load_use) begin
                    stall_cnt <= (stall_cnt != '0) ? stall_cnt - CNT_W'(1) : lu_wait;
                end else begin
                    stall_cnt <= '0;
                end
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall_d) begin
                perf_stall_cycles <= sat_inc(perf_stall_cycles);
            end
            if (flush_d) begin
                perf_flushes <= sat_inc(perf_flushes);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
// dut_a uses the default DEPTH=3 / LOAD_LAT=2, dut_b uses DEPTH=4 / LOAD_LAT=3.
// Each step pushes the expected controls and E-stage selects to a queue; the
// entry is popped and compared at the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic       d_use_rs1;
    logic       d_use_rs2;
    logic [4:0] d_rd;
    logic       d_we;
    logic       d_is_load;
    logic       redirect_valid;
    logic       mem_stall;

    logic       a_sf, a_sd, a_ff, a_fd, a_be;
    logic [1:0] a_s1, a_s2;
    logic       b_sf, b_sd, b_ff, b_fd, b_be;
    logic [1:0] b_s1, b_s2;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] a_perf_stall, a_perf_flush, b_perf_stall, b_perf_flush;
`endif

    int   n_assert;
    int   n_fail;
    logic chk_b;

    // {stall_f, stall_d, flush_f, flush_d, bubble_e}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11001;
    localparam logic [4:0] C_MEM  = 5'b11000;
    localparam logic [4:0] C_RDR  = 5'b00110;

    typedef struct packed {
        logic [4:0] ctl;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .LOAD_LAT(2)) dut_a (
        .clock          (clock),
        .reset          (reset),
        .d_valid        (d_valid),
        .d_rs1          (d_rs1),
        .d_rs2          (d_rs2),
        .d_use_rs1      (d_use_rs1),
        .d_use_rs2      (d_use_rs2),
        .d_rd           (d_rd),
        .d_we           (d_we),
        .d_is_load      (d_is_load),
        .redirect_valid (redirect_valid),
        .mem_stall      (mem_stall),
        .stall_f        (a_sf),
        .stall_d        (a_sd),
        .flush_f        (a_ff),
        .flush_d        (a_fd),
        .bubble_e       (a_be),
        .fwd_rs1_sel    (a_s1),
        .fwd_rs2_sel    (a_s2)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cycles (a_perf_stall),
        .perf_flushes      (a_perf_flush)
`endif
    );

    pipe_hazard_ctrl #(.DEPTH(4), .RA_W(5), .LOAD_LAT(3)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .d_valid        (d_valid),
        .d_rs1          (d_rs1),
        .d_rs2          (d_rs2),
        .d_use_rs1      (d_use_rs1),
        .d_use_rs2      (d_use_rs2),
        .d_rd           (d_rd),
        .d_we           (d_we),
        .d_is_load      (d_is_load),
        .redirect_valid (redirect_valid),
        .mem_stall      (mem_stall),
        .stall_f        (b_sf),
        .stall_d        (b_sd),
        .flush_f        (b_ff),
        .flush_d        (b_fd),
        .bubble_e       (b_be),
        .fwd_rs1_sel    (b_s1),
        .fwd_rs2_sel    (b_s2)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cycles (b_perf_stall),
        .perf_flushes      (b_perf_flush)
`endif
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] ctl, input int s1, input int s2);
        exp_t e;
        e.ctl = ctl;
        e.s1  = 2'(s1);
        e.s2  = 2'(s2);
        exp_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t       e;
        logic [4:0] oc;
        logic [1:0] o1;
        logic [1:0] o2;
        e  = exp_q.pop_front();
        oc = chk_b ? {b_sf, b_sd, b_ff, b_fd, b_be} : {a_sf, a_sd, a_ff, a_fd, a_be};
        o1 = chk_b ? b_s1 : a_s1;
        o2 = chk_b ? b_s2 : a_s2;
        chk({tag, ".stall_f"},  32'(oc[4]), 32'(e.ctl[4]));
        chk({tag, ".stall_d"},  32'(oc[3]), 32'(e.ctl[3]));
        chk({tag, ".flush_f"},  32'(oc[2]), 32'(e.ctl[2]));
        chk({tag, ".flush_d"},  32'(oc[1]), 32'(e.ctl[1]));
        chk({tag, ".bubble_e"}, 32'(oc[0]), 32'(e.ctl[0]));
        chk({tag, ".sel1"},     32'(o1),    32'(e.s1));
        chk({tag, ".sel2"},     32'(o2),    32'(e.s2));
    endtask

    // Inputs are already driven (posedge+1); check at the falling edge.
    task automatic step(input logic [4:0] ctl, input int s1, input int s2, input string tag);
        push(ctl, s1, s2);
        @(negedge clock);
        sample(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic d_nop();
        d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        d_rd = 5'd0; d_we = 1'b0; d_is_load = 1'b0;
    endtask

    task automatic d_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        d_valid = 1'b1; d_rs1 = rs1; d_rs2 = rs2; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
        d_rd = rd; d_we = 1'b1; d_is_load = 1'b0;
    endtask

    task automatic d_addi(input logic [4:0] rd, input logic [4:0] rs1);
        d_valid = 1'b1; d_rs1 = rs1; d_rs2 = 5'd0; d_use_rs1 = 1'b1; d_use_rs2 = 1'b0;
        d_rd = rd; d_we = 1'b1; d_is_load = 1'b0;
    endtask

    task automatic d_lw(input logic [4:0] rd, input logic [4:0] rs1);
        d_valid = 1'b1; d_rs1 = rs1; d_rs2 = 5'd0; d_use_rs1 = 1'b1; d_use_rs2 = 1'b0;
        d_rd = rd; d_we = 1'b1; d_is_load = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        chk_b    = 1'b0;
        reset    = 1'b0;
        d_nop();
        mem_stall      = 1'b1;
        redirect_valid = 1'b1;

        // Reset low: everything quiet despite mem_stall / redirect
        @(posedge clock);
        @(negedge clock);
        push(C_NONE, 0, 0);
        sample("rst_low");
`ifdef PIPE_HAZARD_PERF_EN
        chk("rst_low.perf_stall", a_perf_stall, 32'd0);
        chk("rst_low.perf_flush", a_perf_flush, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(C_NONE, 0, 0, "first_after_rst");
        mem_stall      = 1'b0;
        redirect_valid = 1'b0;

        // ALU back-to-back
        d_alu(5, 1, 2);  step(C_NONE, 0, 0, "alu0_prod");
        d_alu(6, 5, 5);  step(C_NONE, 0, 0, "alu0_cons");
        d_nop();         step(C_NONE, 1, 1, "alu0_e");
        // One NOP between
        d_alu(5, 1, 2);  step(C_NONE, 0, 0, "alu1_prod");
        d_nop();         step(C_NONE, 0, 0, "alu1_gap");
        d_alu(6, 5, 5);  step(C_NONE, 0, 0, "alu1_cons");
        d_nop();         step(C_NONE, 2, 2, "alu1_e");
        // Two NOPs between
        d_alu(5, 1, 2);  step(C_NONE, 0, 0, "alu2_prod");
        d_nop();         step(C_NONE, 0, 0, "alu2_gap0");
        d_nop();         step(C_NONE, 0, 0, "alu2_gap1");
        d_alu(6, 5, 5);  step(C_NONE, 0, 0, "alu2_cons");
        d_nop();         step(C_NONE, 0, 0, "alu2_e");

        // x0 writer never forwards
        d_addi(0, 0);    step(C_NONE, 0, 0, "x0_prod");
        d_alu(1, 0, 0);  step(C_NONE, 0, 0, "x0_cons");
        d_nop();         step(C_NONE, 0, 0, "x0_e");

        // Load-use, one bubble
        d_lw(7, 2);      step(C_NONE, 0, 0, "lu_load");
        d_alu(8, 7, 0);  step(C_LU,   0, 0, "lu_stall");
                         step(C_NONE, 0, 0, "lu_release");
        d_nop();         step(C_NONE, 2, 0, "lu_e");

        // Redirect beats a pending load-use
        d_lw(9, 3);      step(C_NONE, 0, 0, "rdr_load");
        d_alu(10, 9, 9);
        redirect_valid = 1'b1;
                         step(C_RDR,  0, 0, "rdr_flush");
        redirect_valid = 1'b0;
        d_alu(12, 10, 9); step(C_NONE, 0, 0, "rdr_next");
        d_nop();         step(C_NONE, 0, 2, "rdr_e");

        // mem_stall for 3 cycles mid-stream
        d_alu(13, 1, 2); step(C_NONE, 0, 0, "mem_prod");
        d_alu(14, 13, 13);
        mem_stall = 1'b1;
                         step(C_MEM,  0, 0, "mem_hold0");
                         step(C_MEM,  0, 0, "mem_hold1");
                         step(C_MEM,  0, 0, "mem_hold2");
        mem_stall = 1'b0;
                         step(C_NONE, 0, 0, "mem_release");
        d_alu(15, 14, 13); step(C_NONE, 1, 1, "mem_cons_e");
        // Redirect raised during mem_stall acts only after release
        d_nop();
        mem_stall      = 1'b1;
        redirect_valid = 1'b1;
                         step(C_MEM,  1, 2, "mem_rdr_hold");
        mem_stall = 1'b0;
                         step(C_RDR,  1, 2, "mem_rdr_act");
        redirect_valid = 1'b0;
                         step(C_NONE, 0, 0, "mem_rdr_after");

        // Reset asserted in the middle of a load-use stall
        d_lw(7, 2);      step(C_NONE, 0, 0, "rstlu_load");
        d_alu(8, 7, 7);
        push(C_LU, 0, 0);
        @(negedge clock);
        sample("rstlu_stall");
        #2;
        reset = 1'b0;
        push(C_NONE, 0, 0);
        #1;
        sample("rstlu_async");
`ifdef PIPE_HAZARD_PERF_EN
        chk("rstlu.perf_stall_a", a_perf_stall, 32'd0);
        chk("rstlu.perf_flush_a", a_perf_flush, 32'd0);
        chk("rstlu.perf_stall_b", b_perf_stall, 32'd0);
        chk("rstlu.perf_flush_b", b_perf_flush, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
                         step(C_NONE, 0, 0, "rstlu_first");
        d_nop();         step(C_NONE, 0, 0, "rstlu_issue");

        // DEPTH=4, LOAD_LAT=3 instance: two stall cycles, then select 3
        chk_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(C_NONE, 0, 0, "b_drain");
        end
        d_lw(7, 2);      step(C_NONE, 0, 0, "b_load");
        d_alu(8, 7, 0);  step(C_LU,   0, 0, "b_stall0");
                         step(C_LU,   0, 0, "b_stall1");
                         step(C_NONE, 0, 0, "b_release");
        d_nop();         step(C_NONE, 3, 0, "b_e");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and interlock controller for the in-order RISC-V pipeline. It replaces open-coded daisy-chained control with a tracked chain of in-flight destination entries.
- Sits beside decode:
  - watches the instruction leaving D and the DEPTH stages after it (E, M, WB by default);
  - drives stall/flush/bubble controls and registered forwarding selects for the E-stage operands.
- Generalises the fixed 5-stage arrangement to arbitrary post-decode depth and load latency, and adds load-use stalls, redirect flush and external memory stall.

Parameters:
- DEPTH, 3, tracked stages after D (entry 0 = E, entry DEPTH-1 = last writeback stage); minimum 2.
- RA_W, 5, register address width.
- LOAD_LAT, 2, entry index at which load data first becomes forwardable; range 1..DEPTH-1.
- SEL_W, $clog2(DEPTH), forwarding-select width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  D holds a real instruction.
- d_rs1, d_rs2  in  RA_W  source register addresses in D.
- d_use_rs1, d_use_rs2  in  1  source is actually read.
- d_rd  in  RA_W  destination in D.
- d_we  in  1  D instruction writes rd.
- d_is_load  in  1  D instruction is a load.
- redirect_valid  in  1  branch taken / jump resolved in E.
- mem_stall  in  1  dmem not ready; freeze whole pipe.
- stall_f, stall_d  out  1  hold PC / hold D register.
- flush_f, flush_d  out  1  kill F / D contents.
- bubble_e  out  1  load a NOP into E.
- fwd_rs1_sel, fwd_rs2_sel  out  SEL_W  operand source for the E instruction: 0 = regfile value latched at D; k = entry k result.

Behaviour:
- State:
  - entry[0..DEPTH-1], each {valid, rd, we, is_load};
  - stall_cnt, width $clog2(LOAD_LAT+1);
  - registered fwd selects.
- Reset (asynchronous, reset low): all entries invalid, stall_cnt = 0, fwd selects = 0. Every output is 0 while reset is low and in the first cycle after release.
- Advance (mem_stall low): entry[k+1] <= entry[k]. entry[0] loads the D instruction, or an invalid entry when bubble_e or flush_d is asserted.
- Freeze (mem_stall high):
  - no entry, counter or select changes;
  - stall_f = stall_d = 1, bubble_e = 0;
  - redirect_valid is ignored; its source holds it until mem_stall drops.
- Match rule: entry k matches source s when valid, we, rd != 0, rd == s, and the corresponding d_use bit is set. x0 never matches.
- Load-use:
  - Condition: D source matches a load in entry j with j < LOAD_LAT-1.
  - Response: stall_f = stall_d = bubble_e = 1.
  - Counter: stall_cnt loads LOAD_LAT-1-j-1 and decrements each cycle. The stall is held until the condition clears, which is naturally after LOAD_LAT-1-j cycles.
  - Defaults: LOAD_LAT = 2 gives exactly 1 bubble.
- Redirect (redirect_valid high and entry[0].valid):
  - flush_f = flush_d = 1 combinationally;
  - PC is not stalled;
  - next entry[0] is invalid;
  - stall_cnt clears;
  - redirect beats load-use, so stall and bubble are 0 that cycle.
- Forwarding:
  - At advance, for each D source compute the lowest k in 1..DEPTH-1 such that entry[k-1] matches. That entry becomes entry k next cycle.
  - A load entry qualifies only when k >= LOAD_LAT.
  - With no match the select is 0. The result registers into fwd_*_sel, so it is valid while the instruction sits in E.
  - Youngest producer wins.
- Simultaneous stall and redirect from a younger E instruction: redirect first, as above.
- Bubbles and flushed slots never match.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - adds outputs perf_stall_cycles [31:0] (counts load-use stall cycles plus mem_stall cycles) and perf_flushes [31:0] (counts redirects accepted);
  - both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - RA_W default;
  - FWD_REGFILE = 0;
  - typedef hz_entry_t {valid, rd, we, is_load}.
- Sub-module fwd_match: combinational priority encoder over the entries for one source address, returning a select and a load-use hit. It is instantiated once per source.

Test Plan:
- ALU dependency: ADD x5 then ADD x6,x5,x5 back-to-back -> no stall; in E, fwd_rs1_sel = fwd_rs2_sel = 1. With one NOP between them -> sel = 2. Two NOPs -> sel = 0.
- Load-use: LW x7 then ADD x8,x7,x0 -> stall_f = stall_d = bubble_e = 1 for exactly 1 cycle; ADD then sees fwd_rs1_sel = 2. Repeat with LOAD_LAT = 3, DEPTH = 4 -> 2 stall cycles, then sel = 3.
- Redirect: redirect_valid while load-use pending -> flush_f = flush_d = 1, stall = 0; next cycle entry 0 invalid and no forwarding from the killed instruction.
- mem_stall: held 3 cycles mid-stream -> stall_f = stall_d = 1, selects and entries unchanged; after release the sequence continues with the correct selects. Redirect asserted during mem_stall acts only after release.
- x0 writer: ADDI x0 then ADD x1,x0,x0 -> sel = 0, no stall.
- Reset mid load-use stall: async assertion -> all outputs 0 immediately. After release, first instruction proceeds without a stall. With PIPE_HAZARD_PERF_EN, counters read 0.
